leiwand_rv32_mem_arbiter: RTL and testbench
===========================================

// Module: leiwand_rv32_mem_arbiter
// PURPOSE
//  Shares the 8-bit Wishbone byte RAM between two 32-bit requesters:
//  port 0 (instruction fetch) and port 1 (load/store unit).
//  Arbitrates round-robin and splits each 1/2/4-byte access into sequential
//  single-byte RAM transactions, little-endian.
//  Sits between the core and the RAM; it is the only master on the RAM bus.
// PARAMETERS
//  ADDR_W   5   byte-address width of RAM and requesters (>=2)
//  TIMEOUT  15  max cycles to wait for i_wb_ack per byte before abort (>=3)
// PORTS
//  i_clk       in   1       clock, all state on posedge
//  i_rst       in   1       synchronous reset, active-high
//  i_pN_req    in   1       N=0,1: request, held high until o_pN_done/o_pN_err
//  i_pN_addr   in   ADDR_W  byte address, stable while i_pN_req
//  i_pN_we     in   1       1=write, 0=read
//  i_pN_size   in   2       0=byte 1=half 2=word 3=illegal
//  i_pN_wdat   in   32      write data, byte k at [8k+7:8k]
//  o_pN_rdat   out  32      read data, zero-extended, valid with o_pN_done
//  o_pN_done   out  1       one-cycle completion pulse
//  o_pN_err    out  1       one-cycle error pulse (misalign/illegal size/timeout)
//  o_wb_cyc    out  1       bus cycle, high for the whole multi-byte access
//  o_wb_stb    out  1       one-cycle strobe per byte
//  o_wb_we     out  1       write enable
//  o_wb_addr   out  ADDR_W  byte address
//  o_wb_dat    out  8       write byte
//  i_wb_dat    in   8       read byte, valid when i_wb_ack
//  i_wb_ack    in   1       byte transaction complete
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; byte counter 0; last_grant=1 (so p0 wins first tie).
//  States: IDLE -> ISSUE -> WAIT -> (ISSUE | DONE | ERR) -> IDLE.
//  IDLE: if exactly one req, grant it; if both, grant port != last_grant.
//   Latch addr/we/size/wdat of granted port, set last_grant.
//   size==3 or misaligned (half: addr[0]!=0; word: addr[1:0]!=0) -> ERR, no bus activity.
//   Else n = 1/2/4 bytes, k=0 -> ISSUE.
//  ISSUE (1 cycle): cyc=1, stb=1, addr=base+k, we, dat=wdat byte k -> WAIT.
//  WAIT: cyc=1, stb=0; addr/we/dat held stable; timeout counter increments.
//   On i_wb_ack: reads store i_wb_dat into capture byte k; if k==n-1 -> DONE,
//   else k+=1, clear timeout, -> ISSUE. Counter reaching TIMEOUT w/o ack -> ERR.
//  DONE (1 cycle): cyc=0; o_pN_done=1 for granted port; -> IDLE.
//  ERR (1 cycle): cyc=0, stb=0; o_pN_err=1 for granted port; -> IDLE.
//  i_wb_stall is not used; stb is never held more than one cycle.
//  Capture register cleared at each grant; unread upper bytes read 0.
//  o_p0_rdat and o_p1_rdat both show the capture register; valid only with done.
//  Address base+k never wraps: aligned access within 2^ADDR_W.
//  Writes return o_pN_rdat=0.
//  Latency, slave acking 2 cycles after stb: grant edge -> done in 3n+1 cycles
//   (byte 4, half 7, word 13). No new grant before the IDLE cycle after done/err.
//  Req dropped mid-access: access still completes and pulses done.
//  Req re-sampled only in IDLE.
//  i_rst mid-access: next edge cyc=stb=0, no done/err pulse, state IDLE.
// TESTING
//  1. p1 word write 0xDDCCBBAA @0x04, RAM model -> bytes AA,BB,CC,DD at 4..7,
//     4 stb pulses, cyc continuous, done after 13 cycles.
//  2. p0 word read @0x04 -> o_p0_rdat=0xDDCCBBAA; half read @0x06 -> 0x0000DDCC;
//     byte @0x07 -> 0x000000DD.
//  3. p0 and p1 request together from reset -> p0 served first, then p1;
//     held requests keep alternating p0,p1,p0.
//  4. p1 half @0x03 and size=3 -> o_p1_err pulse 1 cycle after grant,
//     cyc/stb never asserted.
//  5. Slave never acks -> o_pN_err after TIMEOUT cycles in WAIT, cyc drops, next request served.
//  6. Assert i_rst during WAIT of word write -> cyc/stb 0 next cycle,
//     no done; fresh request after reset completes normally.

Source files
------------

// File: rtl/leiwand_rv32_mem_arbiter.sv
// Round-robin arbiter that lets the fetch port (p0) and the load/store port (p1)
// share the 8-bit Wishbone byte RAM, splitting 1/2/4-byte accesses into byte cycles.
module leiwand_rv32_mem_arbiter #(
    parameter int ADDR_W  = 5,
    parameter int TIMEOUT = 15
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_p0_req,
    input  logic [ADDR_W-1:0] i_p0_addr,
    input  logic              i_p0_we,
    input  logic [1:0]        i_p0_size,
    input  logic [31:0]       i_p0_wdat,
    output logic [31:0]       o_p0_rdat,
    output logic              o_p0_done,
    output logic              o_p0_err,
    input  logic              i_p1_req,
    input  logic [ADDR_W-1:0] i_p1_addr,
    input  logic              i_p1_we,
    input  logic [1:0]        i_p1_size,
    input  logic [31:0]       i_p1_wdat,
    output logic [31:0]       o_p1_rdat,
    output logic              o_p1_done,
    output logic              o_p1_err,
    output logic              o_wb_cyc,
    output logic              o_wb_stb,
    output logic              o_wb_we,
    output logic [ADDR_W-1:0] o_wb_addr,
    output logic [7:0]        o_wb_dat,
    input  logic [7:0]        i_wb_dat,
    input  logic              i_wb_ack
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    localparam int TW = $clog2(TIMEOUT + 1);

    state_t            state;
    state_t            state_nxt;
    logic              gnt;
    logic              last_grant;
    logic              we_r;
    logic [ADDR_W-1:0] base_r;
    logic [31:0]       wdat_r;
    logic [31:0]       cap_r;
    logic [1:0]        k_r;
    logic [1:0]        k_last;
    logic [TW-1:0]     tcnt;

    logic              sel;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [1:0]        sel_size;
    logic [31:0]       sel_wdat;
    logic              sel_bad;
    logic              do_grant;
    logic              do_capture;
    logic              do_adv;

    // On a tie the port that did not win last time gets the bus.
    always_comb begin
        if (i_p0_req && i_p1_req) begin
            sel = ~last_grant;
        end else begin
            sel = i_p1_req;
        end
        sel_addr = sel ? i_p1_addr : i_p0_addr;
        sel_we   = sel ? i_p1_we   : i_p0_we;
        sel_size = sel ? i_p1_size : i_p0_size;
        sel_wdat = sel ? i_p1_wdat : i_p0_wdat;
        sel_bad  = (sel_size == 2'd3)
                || (sel_size == 2'd1 && sel_addr[0])
                || (sel_size == 2'd2 && sel_addr[1:0] != 2'b00);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        do_grant   = 1'b0;
        do_capture = 1'b0;
        do_adv     = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_p0_req || i_p1_req) begin
                    do_grant  = 1'b1;
                    state_nxt = sel_bad ? S_ERR : S_ISSUE;
                end
            end
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT: begin
                if (i_wb_ack) begin
                    do_capture = ~we_r;
                    if (k_r == k_last) begin
                        state_nxt = S_DONE;
                    end else begin
                        do_adv    = 1'b1;
                        state_nxt = S_ISSUE;
                    end
                end else if (tcnt == TW'(TIMEOUT - 1)) begin
                    state_nxt = S_ERR;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            S_ERR:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            gnt        <= 1'b0;
            last_grant <= 1'b1;
            we_r       <= 1'b0;
            base_r     <= '0;
            wdat_r     <= '0;
            cap_r      <= '0;
            k_r        <= '0;
            k_last     <= '0;
            tcnt       <= '0;
        end else begin
            if (do_grant) begin
                gnt        <= sel;
                last_grant <= sel;
                we_r       <= sel_we;
                base_r     <= sel_addr;
                wdat_r     <= sel_wdat;
                cap_r      <= '0;
                k_r        <= '0;
                k_last     <= (sel_size == 2'd2) ? 2'd3 : (sel_size == 2'd1) ? 2'd1 : 2'd0;
            end
            if (do_capture) begin
                cap_r[{k_r, 3'b000} +: 8] <= i_wb_dat;
            end
            if (do_adv) begin
                k_r <= k_r + 2'd1;
            end
            // Timeout restarts for every byte; only WAIT cycles without ack count.
            if (state == S_WAIT && !i_wb_ack) begin
                tcnt <= tcnt + TW'(1);
            end else begin
                tcnt <= '0;
            end
        end
    end

    assign o_wb_cyc  = (state == S_ISSUE) || (state == S_WAIT);
    assign o_wb_stb  = (state == S_ISSUE);
    assign o_wb_we   = o_wb_cyc && we_r;
    assign o_wb_addr = base_r + ADDR_W'(k_r);
    assign o_wb_dat  = wdat_r[{k_r, 3'b000} +: 8];

    assign o_p0_rdat = cap_r;
    assign o_p1_rdat = cap_r;
    assign o_p0_done = (state == S_DONE) && !gnt;
    assign o_p1_done = (state == S_DONE) &&  gnt;
    assign o_p0_err  = (state == S_ERR)  && !gnt;
    assign o_p1_err  = (state == S_ERR)  &&  gnt;
endmodule

// File: tb/tb_leiwand_rv32_mem_arbiter.sv
// Bench for leiwand_rv32_mem_arbiter: byte RAM slave, reference model with an
// expected-completion queue, and a monitor that checks every done/err pulse.
module tb_leiwand_rv32_mem_arbiter;
    localparam int ADDR_W  = 5;
    localparam int TIMEOUT = 15;
    localparam int W       = 34;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              p0_req = 1'b0, p0_we = 1'b0;
    logic [ADDR_W-1:0] p0_addr = '0;
    logic [1:0]        p0_size = '0;
    logic [31:0]       p0_wdat = '0;
    logic [31:0]       p0_rdat;
    logic              p0_done, p0_err;
    logic              p1_req = 1'b0, p1_we = 1'b0;
    logic [ADDR_W-1:0] p1_addr = '0;
    logic [1:0]        p1_size = '0;
    logic [31:0]       p1_wdat = '0;
    logic [31:0]       p1_rdat;
    logic              p1_done, p1_err;
    logic              wb_cyc, wb_stb, wb_we;
    logic [ADDR_W-1:0] wb_addr;
    logic [7:0]        wb_dat;
    logic [7:0]        wb_rdat = 8'h00;
    logic              wb_ack = 1'b0;

    logic [7:0]   ram [32];
    logic [7:0]   ref_mem [32];
    logic [W-1:0] exp_q[$];   // {port, is_err, rdat}
    int           tests = 0;
    int           fails = 0;
    bit           no_ack = 1'b0;
    bit           model_last = 1'b1;
    int           stb_cnt = 0;
    int           cyc_rise = 0;
    int           proto_bad = 0;

    always #5 clk = ~clk;

    leiwand_rv32_mem_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_p0_req(p0_req), .i_p0_addr(p0_addr), .i_p0_we(p0_we), .i_p0_size(p0_size),
        .i_p0_wdat(p0_wdat), .o_p0_rdat(p0_rdat), .o_p0_done(p0_done), .o_p0_err(p0_err),
        .i_p1_req(p1_req), .i_p1_addr(p1_addr), .i_p1_we(p1_we), .i_p1_size(p1_size),
        .i_p1_wdat(p1_wdat), .o_p1_rdat(p1_rdat), .o_p1_done(p1_done), .o_p1_err(p1_err),
        .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we), .o_wb_addr(wb_addr),
        .o_wb_dat(wb_dat), .i_wb_dat(wb_rdat), .i_wb_ack(wb_ack)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    // Reference: decides error/ok, updates the shadow memory, returns the expected completion.
    function automatic logic [W-1:0] model(input bit p, input logic [ADDR_W-1:0] a, input bit we,
                                           input logic [1:0] sz, input logic [31:0] wd,
                                           output int stbs, output int lat);
        int n;
        logic [31:0] rd;
        model_last = p;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        rd = 32'h0;
        if (sz == 2'd3 || (int'(a) % n) != 0) begin
            stbs = 0;
            lat  = 1;
            return {p, 1'b1, 32'h0};
        end
        if (no_ack) begin
            stbs = 1;
            lat  = TIMEOUT + 2;
            return {p, 1'b1, 32'h0};
        end
        for (int i = 0; i < n; i++) begin
            if (we) ref_mem[int'(a) + i] = wd[8*i +: 8];
            else    rd[8*i +: 8] = ref_mem[int'(a) + i];
        end
        stbs = n;
        lat  = 3 * n + 1;
        return {p, 1'b0, (we ? 32'h0 : rd)};
    endfunction

    // Byte RAM slave: acks two cycles after each strobe unless no_ack is set.
    initial begin
        int cnt;
        bit pend;
        logic [ADDR_W-1:0] sa;
        logic sw;
        logic [7:0] sd;
        cnt = 0;
        pend = 1'b0;
        for (int i = 0; i < 32; i++) ram[i] = 8'(i * 37 + 5);
        forever begin
            @(negedge clk);
            wb_ack = 1'b0;
            if (rst) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    cnt--;
                    if (cnt == 0) begin
                        pend = 1'b0;
                        if (!no_ack) begin
                            wb_ack = 1'b1;
                            if (sw) ram[sa] = sd;
                            else    wb_rdat = ram[sa];
                        end
                    end
                end
                if (wb_stb) begin
                    pend = 1'b1;
                    cnt  = 2;
                    sa   = wb_addr;
                    sw   = wb_we;
                    sd   = wb_dat;
                end
            end
        end
    end

    // Bus watcher: strobe count, cyc rising edges, strobe protocol violations.
    initial begin
        logic prev_cyc, prev_stb;
        prev_cyc = 1'b0;
        prev_stb = 1'b0;
        forever begin
            @(negedge clk);
            if (wb_stb) stb_cnt++;
            if (wb_cyc && !prev_cyc) cyc_rise++;
            if ((wb_stb && prev_stb) || (wb_stb && !wb_cyc)) proto_bad++;
            prev_cyc = wb_cyc;
            prev_stb = wb_stb;
        end
    end

    // Monitor: every completion pulse pops and checks one expected entry.
    initial begin
        logic d, e;
        logic [31:0] rd;
        logic [W-1:0] ent;
        forever begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                d  = (p == 1) ? p1_done : p0_done;
                e  = (p == 1) ? p1_err  : p0_err;
                rd = (p == 1) ? p1_rdat : p0_rdat;
                if (d || e) begin
                    check("done_err_exclusive", 32'(d & e), 32'd0);
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_completion: port %0d done=%0b err=%0b, required none", p, d, e);
                    end else begin
                        ent = exp_q.pop_front();
                        check("completion_port", 32'(p), 32'(ent[33]));
                        check("completion_is_err", 32'(e), 32'(ent[32]));
                        if (d && !ent[32]) check("completion_rdat", rd, ent[31:0]);
                    end
                end
            end
        end
    end

    task automatic access(input bit p, input logic [ADDR_W-1:0] a, input bit we,
                          input logic [1:0] sz, input logic [31:0] wd, input string name,
                          output logic [31:0] got);
        int exp_stb, exp_lat, lat, s0, c0, b0;
        bit seen;
        exp_q.push_back(model(p, a, we, sz, wd, exp_stb, exp_lat));
        s0 = stb_cnt;
        c0 = cyc_rise;
        b0 = proto_bad;
        if (p) begin
            p1_addr = a; p1_we = we; p1_size = sz; p1_wdat = wd; p1_req = 1'b1;
        end else begin
            p0_addr = a; p0_we = we; p0_size = sz; p0_wdat = wd; p0_req = 1'b1;
        end
        lat = 0;
        seen = 1'b0;
        got = 32'h0;
        while (!seen && lat < 200) begin
            @(negedge clk);
            lat++;
            if (p ? (p1_done || p1_err) : (p0_done || p0_err)) begin
                seen = 1'b1;
                got = p ? p1_rdat : p0_rdat;
                check({name, "_cyc_low_at_end"}, 32'(wb_cyc), 32'd0);
            end
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
        check({name, "_finished"}, 32'(seen), 32'd1);
        check({name, "_latency"}, 32'(lat), 32'(exp_lat));
        check({name, "_stb_pulses"}, 32'(stb_cnt - s0), 32'(exp_stb));
        check({name, "_cyc_rises"}, 32'(cyc_rise - c0), (exp_stb > 0) ? 32'd1 : 32'd0);
        check({name, "_stb_protocol"}, 32'(proto_bad - b0), 32'd0);
        @(negedge clk);
    endtask

    // Both ports request and hold; the model predicts the grant order.
    task automatic contend(input int rounds,
                           input logic [ADDR_W-1:0] a0, input bit we0, input logic [1:0] s0, input logic [31:0] w0,
                           input logic [ADDR_W-1:0] a1, input bit we1, input logic [1:0] s1, input logic [31:0] w1,
                           input string name, output bit first_port);
        int st, lt, done_n, cyc_n;
        for (int r = 0; r < rounds; r++) begin
            if (!model_last) exp_q.push_back(model(1'b1, a1, we1, s1, w1, st, lt));
            else             exp_q.push_back(model(1'b0, a0, we0, s0, w0, st, lt));
        end
        p0_addr = a0; p0_we = we0; p0_size = s0; p0_wdat = w0;
        p1_addr = a1; p1_we = we1; p1_size = s1; p1_wdat = w1;
        p0_req = 1'b1;
        p1_req = 1'b1;
        done_n = 0;
        cyc_n = 0;
        first_port = 1'b0;
        while (done_n < rounds && cyc_n < 100 * rounds) begin
            @(negedge clk);
            cyc_n++;
            if (p0_done || p0_err || p1_done || p1_err) begin
                if (done_n == 0) first_port = p1_done || p1_err;
                done_n++;
            end
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
        check({name, "_finished"}, 32'(done_n), 32'(rounds));
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] got;
        bit first;
        int lat;
        logic [ADDR_W-1:0] ra;
        logic [1:0] rs;
        for (int i = 0; i < 32; i++) ref_mem[i] = 8'(i * 37 + 5);

        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_last = 1'b1;
        check("rst_cyc", 32'(wb_cyc), 32'd0);
        check("rst_stb", 32'(wb_stb), 32'd0);
        check("rst_we", 32'(wb_we), 32'd0);
        check("rst_addr", 32'(wb_addr), 32'd0);
        check("rst_dat", 32'(wb_dat), 32'd0);
        check("rst_pulses", 32'({p0_done, p0_err, p1_done, p1_err}), 32'd0);
        check("rst_rdat", p0_rdat | p1_rdat, 32'd0);

        // Contention from reset: p0 first, then alternating while held.
        contend(4, 5'd0, 1'b0, 2'd2, 32'h0, 5'd8, 1'b0, 2'd2, 32'h0, "t3_alt", first);
        check("t3_first_is_p0", 32'(first), 32'd0);

        access(1'b1, 5'd4, 1'b1, 2'd2, 32'hDDCCBBAA, "t1_word_wr", got);
        check("t1_ram4", 32'(ram[4]), 32'hAA);
        check("t1_ram5", 32'(ram[5]), 32'hBB);
        check("t1_ram6", 32'(ram[6]), 32'hCC);
        check("t1_ram7", 32'(ram[7]), 32'hDD);
        check("t1_wr_rdat", got, 32'h0);

        access(1'b0, 5'd4, 1'b0, 2'd2, 32'h0, "t2_word_rd", got);
        check("t2_word_val", got, 32'hDDCCBBAA);
        access(1'b0, 5'd6, 1'b0, 2'd1, 32'h0, "t2_half_rd", got);
        check("t2_half_val", got, 32'h0000DDCC);
        access(1'b0, 5'd7, 1'b0, 2'd0, 32'h0, "t2_byte_rd", got);
        check("t2_byte_val", got, 32'h000000DD);

        access(1'b1, 5'd3, 1'b0, 2'd1, 32'h0, "t4_misalign", got);
        access(1'b1, 5'd8, 1'b1, 2'd3, 32'h12345678, "t4_size3", got);
        access(1'b0, 5'd6, 1'b0, 2'd2, 32'h0, "t4_word_mis", got);

        no_ack = 1'b1;
        access(1'b0, 5'd8, 1'b0, 2'd2, 32'h0, "t5_timeout", got);
        no_ack = 1'b0;
        access(1'b1, 5'd12, 1'b0, 2'd2, 32'h0, "t5_after", got);

        // Reset while the first byte of a word write is outstanding.
        p1_addr = 5'd16; p1_we = 1'b1; p1_size = 2'd2; p1_wdat = 32'h11223344; p1_req = 1'b1;
        lat = 0;
        while (!wb_stb && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("t6_stb_seen", 32'(wb_stb), 32'd1);
        @(negedge clk);
        check("t6_in_wait", 32'({wb_cyc, wb_stb}), 32'b10);
        rst = 1'b1;
        p1_req = 1'b0;
        @(negedge clk);
        check("t6_rst_cyc_stb", 32'({wb_cyc, wb_stb}), 32'd0);
        check("t6_rst_no_pulse", 32'({p0_done, p0_err, p1_done, p1_err}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_last = 1'b1;
        @(negedge clk);
        access(1'b1, 5'd16, 1'b1, 2'd2, 32'h55667788, "t6_fresh_wr", got);
        access(1'b0, 5'd16, 1'b0, 2'd2, 32'h0, "t6_fresh_rd", got);
        check("t6_fresh_val", got, 32'h55667788);

        for (int i = 0; i < 40; i++) begin
            rs = 2'($urandom_range(0, 3));
            ra = ADDR_W'($urandom_range(0, 31));
            if ($urandom_range(0, 3) != 0) ra = ra & ((rs == 2'd0) ? 5'h1F : (rs == 2'd1) ? 5'h1E : 5'h1C);
            access(1'($urandom_range(0, 1)), ra, 1'($urandom_range(0, 1)), rs, $urandom, "rnd", got);
            if (i % 5 == 0) begin
                contend(2, ADDR_W'($urandom_range(0, 7) * 4), 1'($urandom_range(0, 1)), 2'd2, $urandom,
                        ADDR_W'($urandom_range(0, 15) * 2), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 1)),
                        $urandom, "rnd_pair", first);
            end
        end

        repeat (3) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        fails++;
        $display("FAIL watchdog: simulation time limit reached, required completion before it");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end
endmodule
